// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared widths, nominal oversampling ratios and line constants for the UART receiver
package uart_rx_pkg;
  localparam int DEF_PRESCALE_W = 6;
  localparam int DEF_BITCNT_W = 4;
  localparam int PRESCALE_X8 = 8;
  localparam int PRESCALE_X16 = 16;
  localparam int PRESCALE_X32 = 32;
  localparam int MIN_PRESCALE = 4;
  localparam logic IDLE_LVL = 1'b1;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/rx_edge_bit_counter.sv
// rx_edge_bit_counter: per-bit oversample counter and per-frame bit counter with registered Frame_Done
module rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int BITCNT_W = DEF_BITCNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BITCNT_W-1:0]   frame_len,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BITCNT_W-1:0]   bit_cnt,
  output logic                  frame_done
);
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic frame_done_q, frame_done_d;
  logic last_edge, last_bit;
  always_comb begin
    last_edge = edge_cnt_q >= prescale - PRESCALE_W'(1);
    last_bit = bit_cnt_q >= frame_len - BITCNT_W'(1);
    edge_cnt_d = (!en || last_edge) ? '0 : edge_cnt_q + PRESCALE_W'(1);
    bit_cnt_d = !en ? '0 : !last_edge ? bit_cnt_q : last_bit ? '0 : bit_cnt_q + BITCNT_W'(1);
    frame_done_d = en && last_edge && last_bit;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_done_q <= frame_done_d;
    end
  assign edge_cnt = edge_cnt_q;
  assign bit_cnt = bit_cnt_q;
  assign frame_done = frame_done_q;
endmodule

// File: rtl/rx_bit_sampler.sv
// rx_bit_sampler: UART RX line synchroniser and mid-bit 3-sample majority voter.
// Define RX_SAMPLER_DISAGREE_EN to drive Sample_Disagree on non-unanimous votes.
module rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int BITCNT_W = DEF_BITCNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  Enable,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [BITCNT_W-1:0]   Frame_Len,
  output logic                  RX_Sync,
  output logic [PRESCALE_W-1:0] Edge_Cnt,
  output logic [BITCNT_W-1:0]   Bit_Cnt,
  output logic                  Sampled_Bit,
  output logic                  Sample_Valid,
  output logic                  Frame_Done,
  output logic                  Sample_Disagree
);
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic s0_q, s0_d, s1_q, s1_d;
  logic sampled_q, sampled_d, valid_q, valid_d, disagree_q, disagree_d;
  logic en;
  logic [PRESCALE_W-1:0] half;
  rx_edge_bit_counter #(.PRESCALE_W(PRESCALE_W), .BITCNT_W(BITCNT_W)) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .en(en),
    .prescale(Prescale),
    .frame_len(Frame_Len),
    .edge_cnt(Edge_Cnt),
    .bit_cnt(Bit_Cnt),
    .frame_done(Frame_Done)
  );
  // The third sample is taken straight from the line so the vote lands at H+1 with no extra stage.
  always_comb begin
    en = Enable && Prescale >= PRESCALE_W'(MIN_PRESCALE) && Frame_Len != '0;
    half = Prescale >> 1;
    sync1_d = RX_IN;
    sync2_d = sync1_q;
    s0_d = (en && Edge_Cnt == half - PRESCALE_W'(2)) ? sync2_q : s0_q;
    s1_d = (en && Edge_Cnt == half - PRESCALE_W'(1)) ? sync2_q : s1_q;
    valid_d = en && Edge_Cnt == half;
    sampled_d = valid_d ? maj3(s0_q, s1_q, sync2_q) : sampled_q;
`ifdef RX_SAMPLER_DISAGREE_EN
    disagree_d = valid_d && !(s0_q == s1_q && s1_q == sync2_q);
`else
    disagree_d = 1'b0;
`endif
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      s0_q <= IDLE_LVL;
      s1_q <= IDLE_LVL;
      sampled_q <= IDLE_LVL;
      valid_q <= 1'b0;
      disagree_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      sampled_q <= sampled_d;
      valid_q <= valid_d;
      disagree_q <= disagree_d;
    end
  assign RX_Sync = sync2_q;
  assign Sampled_Bit = sampled_q;
  assign Sample_Valid = valid_q;
  assign Sample_Disagree = disagree_q;
endmodule

// File: tb/tb_rx_bit_sampler.sv
// tb_rx_bit_sampler: randomized self-checking bench for rx_bit_sampler against a bit-level timing model
module tb_rx_bit_sampler;
  import uart_rx_pkg::*;
`ifdef RX_SAMPLER_DISAGREE_EN
  localparam bit DIS_EN = 1'b1;
`else
  localparam bit DIS_EN = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic RX_IN = 1'b1;
  logic Enable = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [3:0] Frame_Len = 4'd10;
  logic RX_Sync, Sampled_Bit, Sample_Valid, Frame_Done, Sample_Disagree;
  logic [5:0] Edge_Cnt;
  logic [3:0] Bit_Cnt;
  int checks = 0;
  int failures = 0;
  int strobes, dones;
  bit line [0:1023];
  bit exp_sampled = 1'b1;
  bit got_q [$];

  rx_bit_sampler dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Enable(Enable), .Prescale(Prescale),
    .Frame_Len(Frame_Len), .RX_Sync(RX_Sync), .Edge_Cnt(Edge_Cnt), .Bit_Cnt(Bit_Cnt),
    .Sampled_Bit(Sampled_Bit), .Sample_Valid(Sample_Valid), .Frame_Done(Frame_Done),
    .Sample_Disagree(Sample_Disagree)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // line[j] is the level RX_Sync must show in the j-th enabled cycle; RX_IN is driven two cycles ahead.
  task automatic test_frame(input int p, input int l, input int n);
    int h, k, vsum;
    bit ev, ed, efd;
    h = p / 2;
    strobes = 0;
    dones = 0;
    got_q.delete();
    Prescale = 6'(p);
    Frame_Len = 4'(l);
    Enable = 1'b0;
    RX_IN = line[0];
    tick;
    RX_IN = line[1];
    tick;
    for (int j = 0; j <= n; j++) begin
      k = j / p;
      ev = (j % p) == h + 1;
      ed = 1'b0;
      if (ev) begin
        vsum = int'(line[k*p+h-2]) + int'(line[k*p+h-1]) + int'(line[k*p+h]);
        exp_sampled = vsum >= 2;
        ed = DIS_EN && (vsum == 1 || vsum == 2);
      end
      efd = j > 0 && (j % (p * l)) == 0;
      checks++;
      if (Edge_Cnt !== 6'(j % p)) begin
        failures++;
        $display("FAIL edge_cnt p=%0d l=%0d j=%0d got=%0d exp=%0d", p, l, j, Edge_Cnt, j % p);
      end
      checks++;
      if (Bit_Cnt !== 4'((j / p) % l)) begin
        failures++;
        $display("FAIL bit_cnt p=%0d l=%0d j=%0d got=%0d exp=%0d", p, l, j, Bit_Cnt, (j / p) % l);
      end
      checks++;
      if (Sample_Valid !== ev) begin
        failures++;
        $display("FAIL sample_valid p=%0d j=%0d got=%0b exp=%0b", p, j, Sample_Valid, ev);
      end
      checks++;
      if (Sampled_Bit !== exp_sampled) begin
        failures++;
        $display("FAIL sampled_bit p=%0d j=%0d got=%0b exp=%0b", p, j, Sampled_Bit, exp_sampled);
      end
      checks++;
      if (Sample_Disagree !== ed) begin
        failures++;
        $display("FAIL disagree p=%0d j=%0d got=%0b exp=%0b", p, j, Sample_Disagree, ed);
      end
      checks++;
      if (Frame_Done !== efd) begin
        failures++;
        $display("FAIL frame_done p=%0d l=%0d j=%0d got=%0b exp=%0b", p, l, j, Frame_Done, efd);
      end
      checks++;
      if (RX_Sync !== line[j]) begin
        failures++;
        $display("FAIL rx_sync p=%0d j=%0d got=%0b exp=%0b", p, j, RX_Sync, line[j]);
      end
      if (Sample_Valid) begin
        strobes++;
        got_q.push_back(Sampled_Bit);
      end
      if (Frame_Done) dones++;
      Enable = j < n;
      RX_IN = line[j+2];
      tick;
    end
    checks++;
    if ({Edge_Cnt, Bit_Cnt, Sample_Valid, Frame_Done, Sampled_Bit} !== {10'd0, 1'b0, 1'b0, exp_sampled}) begin
      failures++;
      $display("FAIL after_disable p=%0d n=%0d got=%0h/%0h/%0b/%0b/%0b exp=0/0/0/0/%0b",
               p, n, Edge_Cnt, Bit_Cnt, Sample_Valid, Frame_Done, Sampled_Bit, exp_sampled);
    end
  endtask

  task automatic fill_const(input bit v, input int len);
    for (int i = 0; i < len; i++) line[i] = v;
  endtask

  task automatic fill_random(input int p, input int len);
    bit v;
    for (int i = 0; i < len; i++) begin
      if (i % p == 0) v = 1'($urandom_range(0, 1));
      line[i] = v ^ ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic test_reset;
    repeat (2) tick;
    checks++;
    if ({RX_Sync, Edge_Cnt, Bit_Cnt, Sampled_Bit, Sample_Valid, Frame_Done, Sample_Disagree} !== {1'b1, 10'd0, 1'b1, 3'b0}) begin
      failures++;
      $display("FAIL power_on_reset got=%b", {RX_Sync, Edge_Cnt, Bit_Cnt, Sampled_Bit, Sample_Valid, Frame_Done, Sample_Disagree});
    end
    RST = 1'b1;
    tick;
    Prescale = 6'(PRESCALE_X8);
    Frame_Len = 4'd10;
    RX_IN = 1'b0;
    repeat (2) tick;
    Enable = 1'b1;
    repeat (29) tick;
    checks++;
    if ({Edge_Cnt, Bit_Cnt, Sampled_Bit} !== {6'd5, 4'd3, 1'b0}) begin
      failures++;
      $display("FAIL pre_reset_count got=%0d/%0d/%0b exp=5/3/0", Edge_Cnt, Bit_Cnt, Sampled_Bit);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({RX_Sync, Edge_Cnt, Bit_Cnt, Sampled_Bit, Sample_Valid, Frame_Done, Sample_Disagree} !== {1'b1, 10'd0, 1'b1, 3'b0}) begin
      failures++;
      $display("FAIL mid_frame_reset got=%b", {RX_Sync, Edge_Cnt, Bit_Cnt, Sampled_Bit, Sample_Valid, Frame_Done, Sample_Disagree});
    end
    exp_sampled = 1'b1;
    Enable = 1'b0;
    RX_IN = 1'b1;
    tick;
    RST = 1'b1;
    tick;
  endtask

  task automatic test_clean_low;
    fill_const(1'b0, 16);
    test_frame(PRESCALE_X8, 10, 8);
  endtask

  task automatic test_glitch;
    fill_const(1'b0, 16);
    line[7] = 1'b1;
    test_frame(PRESCALE_X16, 10, 10);
  endtask

  task automatic test_full_frame;
    bit pat [10] = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < 8; i++) line[k*8+i] = pat[k];
    fill_const(1'b1, 0);
    for (int i = 80; i < 84; i++) line[i] = 1'b1;
    test_frame(PRESCALE_X8, 10, 80);
    checks++;
    if (strobes != 10 || dones != 1) begin
      failures++;
      $display("FAIL frame_counts got=%0d/%0d exp=10/1", strobes, dones);
    end
    for (int k = 0; k < 10 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== pat[k]) begin
        failures++;
        $display("FAIL frame_bit k=%0d got=%0b exp=%0b", k, got_q[k], pat[k]);
      end
    end
  endtask

  task automatic test_prescale32;
    int lat;
    Enable = 1'b0;
    RX_IN = 1'b1;
    repeat (3) tick;
    RX_IN = 1'b0;
    lat = 0;
    while (RX_Sync !== 1'b0 && lat < 10) begin
      tick;
      lat++;
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL sync_latency got=%0d exp=2", lat);
    end
    fill_random(PRESCALE_X32, 70);
    test_frame(PRESCALE_X32, 2, 64);
  endtask

  task automatic test_enable_drop;
    fill_random(PRESCALE_X8, 20);
    test_frame(PRESCALE_X8, 10, 4);
    fill_random(PRESCALE_X8, 20);
    test_frame(PRESCALE_X8, 10, 12);
    fill_random(PRESCALE_X8, 12);
    test_frame(PRESCALE_X8, 1, 7);
  endtask

  task automatic test_unsupported;
    bit held;
    held = Sampled_Bit;
    for (int c = 0; c < 2; c++) begin
      Prescale = c == 0 ? 6'd3 : 6'd8;
      Frame_Len = c == 0 ? 4'd10 : 4'd0;
      Enable = 1'b1;
      for (int j = 0; j < 20; j++) begin
        RX_IN = 1'($urandom_range(0, 1));
        tick;
        checks++;
        if ({Edge_Cnt, Bit_Cnt, Sample_Valid, Frame_Done, Sampled_Bit} !== {10'd0, 2'b00, held}) begin
          failures++;
          $display("FAIL unsupported c=%0d j=%0d got=%0d/%0d/%0b/%0b/%0b", c, j, Edge_Cnt, Bit_Cnt, Sample_Valid, Frame_Done, Sampled_Bit);
        end
      end
      Enable = 1'b0;
      tick;
    end
  endtask

  task automatic test_random;
    int p, l, n;
    for (int it = 0; it < 12; it++) begin
      p = $urandom_range(4, 40);
      l = $urandom_range(1, 15);
      n = p * l + $urandom_range(0, p);
      fill_random(p, n + 3);
      test_frame(p, l, n);
    end
  endtask

  initial begin
    test_reset;
    test_clean_low;
    test_glitch;
    test_full_frame;
    test_prescale32;
    test_enable_drop;
    test_unsupported;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_bit_sampler.md
Name: rx_bit_sampler

Overview:
Front-end timing stage of the UART receiver. It synchronises the raw serial line and runs the per-bit oversampling edge counter and the per-frame bit counter. It takes three samples around mid-bit, majority-votes them, and presents Sampled_Bit with a one-cycle Sample_Valid strobe. The start-bit checker, the data/parity/stop stages and the RX FSM consume these outputs.

Parameters:
PRESCALE_W, 6, width of Prescale and Edge_Cnt; supports oversampling ratios up to 2^PRESCALE_W-1
BITCNT_W, 4, width of Frame_Len and Bit_Cnt

Ports:
CLK  input  1  receiver oversampling clock
RST  input  1  asynchronous, active-low reset
RX_IN  input  1  raw serial line, idle high, asynchronous to CLK
Enable  input  1  from RX FSM; high while a frame is being received
Prescale  input  PRESCALE_W  oversampling ratio (8/16/32 nominal); static while Enable=1
Frame_Len  input  BITCNT_W  bits per frame incl. start/parity/stop (e.g. 10 or 11); static while Enable=1
RX_Sync  output  1  synchronised RX_IN, for start-edge detection by the FSM
Edge_Cnt  output  PRESCALE_W  current oversample index within bit, 0..Prescale-1
Bit_Cnt  output  BITCNT_W  current bit index within frame, 0..Frame_Len-1
Sampled_Bit  output  1  majority-voted bit value; holds between strobes
Sample_Valid  output  1  one-cycle pulse when Sampled_Bit is updated
Frame_Done  output  1  one-cycle pulse on the last edge of the last bit
Sample_Disagree  output  1  optional-feature flag (see below)

Behaviour:
- Reset (RST=0, async): sync flops=1, RX_Sync=1, Edge_Cnt=0, Bit_Cnt=0, Sampled_Bit=1, Sample_Valid=0, Frame_Done=0, Sample_Disagree=0, vote registers=1.
- Synchroniser: two-flop chain. RX_IN to RX_Sync latency is 2 CLK. All sampling uses RX_Sync only.
- Let H = Prescale>>1. Sample points are Edge_Cnt = H-2, H-1, H. For Prescale=8 these are 2,3,4; for 16: 6,7,8; for 32: 14,15,16.
- Edge counter, Enable=1: increments every CLK. At Prescale-1 it wraps to 0 and Bit_Cnt increments.
- Bit counter: when Edge_Cnt=Prescale-1 and Bit_Cnt=Frame_Len-1, Frame_Done pulses for 1 cycle (registered, i.e. visible in the cycle where Edge_Cnt=0) and Bit_Cnt returns to 0.
- Enable=0: Edge_Cnt and Bit_Cnt cleared next cycle. Sample_Valid and Frame_Done are 0. Sampled_Bit holds its last value.
- Enable falling in the same cycle as a wrap or sample point: clear wins. No Sample_Valid or Frame_Done is produced.
- Vote: the three sample registers capture RX_Sync at their edges. At Edge_Cnt=H+1 the register Sampled_Bit = majority(s0,s1,s2) and Sample_Valid=1 for exactly that one cycle. Per bit there is exactly one strobe, and no strobe before the third sample exists.
- Prescale<4 or Frame_Len=0: unsupported. Counters are held at 0, and Sample_Valid and Frame_Done are never asserted.
- Enable re-asserted mid-bit after deassert: counting restarts from Edge_Cnt=0, Bit_Cnt=0.
- RST asserted mid-frame: all state returns to reset values immediately. After release, normal operation resumes on the next Enable.

Optional Feature:
Macro RX_SAMPLER_DISAGREE_EN.
- Defined: Sample_Disagree is registered alongside Sample_Valid. It is 1 for that strobe cycle when s0,s1,s2 are not unanimous, and 0 otherwise.
- Undefined: Sample_Disagree is tied to 0, the comparison logic is absent, and all other behaviour is identical.

Decomposition:
- Shared package uart_rx_pkg: PRESCALE_W/BITCNT_W defaults, the nominal prescale constants (8/16/32), and the idle-line level constant (1'b1).
- One sub-module: rx_edge_bit_counter (Edge_Cnt/Bit_Cnt/Frame_Done).
- Synchroniser and vote logic stay in the top.

Test Plan:
- Reset check: assert RST mid-count at Edge_Cnt=5, Bit_Cnt=3 -> all outputs return to reset values the same cycle; Sampled_Bit=1.
- Clean low bit, Prescale=8, Enable=1, RX_Sync=0 throughout -> samples at edges 2,3,4; Sampled_Bit=0 and Sample_Valid=1 at Edge_Cnt=5 only.
- Glitch, Prescale=16, RX_Sync high only at edge 7 -> Sampled_Bit=0. With the macro, Sample_Disagree=1; without it, 0.
- Full frame, Prescale=8, Frame_Len=10, pattern 0,1,0,1,1,0,0,1,0,1 -> 10 strobes carrying that sequence, one Frame_Done after 80 enabled cycles, Bit_Cnt back to 0.
- Prescale=32: samples at 14,15,16 and strobe at 17; RX_IN to RX_Sync latency measured as 2 cycles.
- Enable dropped at Edge_Cnt=4 (Prescale=8) -> no strobe, counters 0 next cycle, Sampled_Bit unchanged; re-enable restarts at Edge_Cnt=0.
